vx_fetch_warp_arbiter: RTL and testbench
========================================

# vx_fetch_warp_arbiter

Round-robin warp arbiter that sequences the instruction-fetch datapath: it owns the per-warp PC, active, stall and in-flight state and issues at most one fetch request per cycle toward the icache stage. It sits between the warp-control/branch/stall feedback paths and the fetch request channel. Each warp has at most one outstanding fetch, and a fair rotating priority is kept across warps.

## Interface
- NUM_WARPS, 4, number of warps; power of two, 2..32
- PC_WIDTH, 32, PC width in bits
- RESET_PC, 32'h80000000, PC loaded into warp 0 at reset
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-high reset
- wspawn_valid  in  1  activate warps in wspawn_mask at wspawn_pc
- wspawn_mask  in  NUM_WARPS  warps to spawn
- wspawn_pc  in  PC_WIDTH  start PC for spawned warps
- tmc_valid  in  1  thread-mask control; tmc_wid is deactivated when tmc_active=0
- tmc_wid  in  log2(NUM_WARPS)  target warp
- tmc_active  in  1  0 = deactivate warp, 1 = no-op
- stall_valid  in  1  set stall bit of stall_wid
- stall_wid  in  log2(NUM_WARPS)  warp to stall
- branch_valid  in  1  resolve branch/stall for branch_wid
- branch_wid  in  log2(NUM_WARPS)  target warp
- branch_taken  in  1  1 = load branch_dest
- branch_dest  in  PC_WIDTH  taken target
- req_valid  out  1  fetch request valid (registered)
- req_ready  in  1  downstream accepts request
- req_wid  out  log2(NUM_WARPS)  warp of request
- req_pc  out  PC_WIDTH  fetch PC
- rsp_valid  in  1  fetch for rsp_wid completed
- rsp_wid  in  log2(NUM_WARPS)  completed warp
- busy  out  1  any warp active or any fetch in flight

## Operation
- Per-warp state: active, stalled, inflight, pc[PC_WIDTH].
- eligible[w] = active & ~stalled & ~inflight (registered state only).
- Selection occurs in cycle when slot is free: slot free = ~req_valid | req_ready.
- Selection: first eligible warp at or after rr_ptr, wrapping modulo NUM_WARPS. On select: req_valid<=1, req_wid<=w, req_pc<=pc[w], pc[w]<=pc[w]+4 (modulo 2^PC_WIDTH), inflight[w]<=1, rr_ptr<=w+1 (wraps).
- No eligible warp and slot free: req_valid<=0; rr_ptr unchanged.
- Request hold: while req_valid & ~req_ready, req_wid/req_pc remain stable regardless of other inputs.
- rsp_valid: inflight[rsp_wid]<=0. rsp for a warp without inflight is ignored.
- stall_valid: stalled[stall_wid]<=1.
- branch_valid: stalled[branch_wid]<=0; if branch_taken, pc[branch_wid]<=branch_dest (wins over the +4 of a same-cycle selection of that warp).
- wspawn_valid: for each w in mask: active<=1, pc<=wspawn_pc, stalled<=0. Same-cycle branch to a spawned warp: spawn wins.
- tmc_valid & ~tmc_active: active[tmc_wid]<=0. Pending request/inflight of that warp still completes normally.
- Same-cycle stall_valid and branch_valid on same warp: branch wins (stall cleared).
- Same-cycle rsp_valid and selection: the freed warp is not eligible until next cycle.
- busy = |active | |inflight | req_valid (combinational from registers).

## Timing
- Reset values: req_valid=0, req_wid=0, req_pc=0, rr_ptr=0; active=1 for warp 0 only, pc[0]=RESET_PC, other pcs 0; stalled=0, inflight=0; busy=1 one cycle after reset release.
- Reset asserted mid-request drops req_valid next cycle; pending rsp_valid after reset ignored (inflight already 0).
- Selection latency: eligible at cycle N (state visible), req_valid at N+1.
- Input effects (stall, branch, spawn, tmc, rsp) become visible to selection the cycle after they are sampled.
- Peak throughput: one request per cycle with req_ready held high and ≥2 eligible warps; single warp issues at most every 1+fetch-latency cycles (inflight limited).
- Fire = req_valid & req_ready; no combinational path from req_ready to req_valid/req_wid/req_pc.

## Test plan
- Reset release, req_ready=1, rsp returned 2 cycles after fire -> first request cycle 1: wid=0 pc=0x80000000; next warp-0 request pc=0x80000004 only after rsp.
- wspawn_mask=4'b1110, pc=0x1000, all rsps immediate -> request order wid 0,1,2,3,0,... with warps 1-3 pc 0x1000 then 0x1004.
- req_ready=0 for 5 cycles with request pending -> req_wid/req_pc unchanged all 5 cycles; then ready=1 -> exactly one fire, next warp selected.
- stall_valid wid=1 then branch_valid wid=1 taken dest=0x2000 -> warp 1 skipped until branch; next warp-1 req_pc=0x2000.
- Same cycle: warp 0 selected and branch taken wid=0 dest=0x3000 -> this req_pc=old pc, next warp-0 req_pc=0x3000 (not old+4).
- tmc deactivate all warps, drain rsps -> req_valid=0, busy=0; pc wrap at 0xFFFFFFFC -> next pc 0x00000000.

Source files
------------

// File: rtl/vx_fetch_warp_arbiter.sv
// Round-robin warp arbiter for the fetch stage: owns per-warp PC/active/stall/
// in-flight state and issues at most one registered fetch request per cycle.
module vx_fetch_warp_arbiter #(
    parameter int                  NUM_WARPS = 4,
    parameter int                  PC_WIDTH  = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC  = 32'h80000000,
    localparam int                 WID_W     = $clog2(NUM_WARPS)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 wspawn_valid,
    input  logic [NUM_WARPS-1:0] wspawn_mask,
    input  logic [PC_WIDTH-1:0]  wspawn_pc,
    input  logic                 tmc_valid,
    input  logic [WID_W-1:0]     tmc_wid,
    input  logic                 tmc_active,
    input  logic                 stall_valid,
    input  logic [WID_W-1:0]     stall_wid,
    input  logic                 branch_valid,
    input  logic [WID_W-1:0]     branch_wid,
    input  logic                 branch_taken,
    input  logic [PC_WIDTH-1:0]  branch_dest,
    output logic                 req_valid,
    input  logic                 req_ready,
    output logic [WID_W-1:0]     req_wid,
    output logic [PC_WIDTH-1:0]  req_pc,
    input  logic                 rsp_valid,
    input  logic [WID_W-1:0]     rsp_wid,
    output logic                 busy
);

    logic [NUM_WARPS-1:0] active_q, active_d;
    logic [NUM_WARPS-1:0] stalled_q, stalled_d;
    logic [NUM_WARPS-1:0] inflight_q, inflight_d;
    logic [PC_WIDTH-1:0]  pc_q [NUM_WARPS];
    logic [PC_WIDTH-1:0]  pc_d [NUM_WARPS];
    logic [WID_W-1:0]     rr_ptr_q, rr_ptr_d;
    logic                 req_valid_q, req_valid_d;
    logic [WID_W-1:0]     req_wid_q, req_wid_d;
    logic [PC_WIDTH-1:0]  req_pc_q, req_pc_d;

    logic [NUM_WARPS-1:0] eligible;
    logic                 slot_free;
    logic                 sel_found;
    logic [WID_W-1:0]     sel_wid;
    logic [WID_W-1:0]     cand;

    assign eligible  = active_q & ~stalled_q & ~inflight_q;
    assign slot_free = ~req_valid_q | req_ready;

    // Rotating priority: first eligible warp at or after rr_ptr_q.
    always_comb begin
        sel_found = 1'b0;
        sel_wid   = '0;
        cand      = '0;
        for (int i = 0; i < NUM_WARPS; i++) begin
            cand = rr_ptr_q + WID_W'(i);
            if (!sel_found && eligible[cand]) begin
                sel_found = 1'b1;
                sel_wid   = cand;
            end
        end
    end

    // NOTE: every _d is defaulted to its _q first so no path can infer a latch.
    always_comb begin
        active_d    = active_q;
        stalled_d   = stalled_q;
        inflight_d  = inflight_q;
        pc_d        = pc_q;
        rr_ptr_d    = rr_ptr_q;
        req_valid_d = req_valid_q;
        req_wid_d   = req_wid_q;
        req_pc_d    = req_pc_q;

        // Clear before setting: a selected warp is never inflight, so a stray rsp
        // naming it must not cancel the new in-flight mark.
        if (rsp_valid) inflight_d[rsp_wid] = 1'b0;

        if (slot_free) begin
            req_valid_d = sel_found;
            if (sel_found) begin
                req_wid_d           = sel_wid;
                req_pc_d            = pc_q[sel_wid];
                pc_d[sel_wid]       = pc_q[sel_wid] + PC_WIDTH'(4);
                inflight_d[sel_wid] = 1'b1;
                rr_ptr_d            = sel_wid + WID_W'(1);
            end
        end

        if (stall_valid) stalled_d[stall_wid] = 1'b1;
        if (tmc_valid && !tmc_active) active_d[tmc_wid] = 1'b0;

        // Later assignments take priority: branch over stall/+4, spawn over all.
        if (branch_valid) begin
            stalled_d[branch_wid] = 1'b0;
            if (branch_taken) pc_d[branch_wid] = branch_dest;
        end

        if (wspawn_valid) begin
            for (int w = 0; w < NUM_WARPS; w++) begin
                if (wspawn_mask[w]) begin
                    active_d[w]  = 1'b1;
                    stalled_d[w] = 1'b0;
                    pc_d[w]      = wspawn_pc;
                end
            end
        end
    end

    // NOTE: the PC table is reset too, since warp 0 must boot from RESET_PC.
    always_ff @(posedge clk) begin
        if (reset) begin
            active_q    <= NUM_WARPS'(1);
            stalled_q   <= '0;
            inflight_q  <= '0;
            rr_ptr_q    <= '0;
            req_valid_q <= 1'b0;
            req_wid_q   <= '0;
            req_pc_q    <= '0;
            for (int w = 0; w < NUM_WARPS; w++) begin
                pc_q[w] <= (w == 0) ? RESET_PC : '0;
            end
        end else begin
            active_q    <= active_d;
            stalled_q   <= stalled_d;
            inflight_q  <= inflight_d;
            rr_ptr_q    <= rr_ptr_d;
            req_valid_q <= req_valid_d;
            req_wid_q   <= req_wid_d;
            req_pc_q    <= req_pc_d;
            pc_q        <= pc_d;
        end
    end

    assign req_valid = req_valid_q;
    assign req_wid   = req_wid_q;
    assign req_pc    = req_pc_q;
    assign busy      = (|active_q) | (|inflight_q) | req_valid_q;

endmodule

// File: tb/tb_vx_fetch_warp_arbiter.sv
// Directed bench for vx_fetch_warp_arbiter: a per-cycle vector table plus
// hand-written sequences for stall/branch, same-cycle branch, drain and PC wrap.
module tb_vx_fetch_warp_arbiter;

    localparam int NW = 4;
    localparam int PW = 32;
    localparam int WW = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          wspawn_valid = 1'b0;
    logic [NW-1:0] wspawn_mask = '0;
    logic [PW-1:0] wspawn_pc = '0;
    logic          tmc_valid = 1'b0;
    logic [WW-1:0] tmc_wid = '0;
    logic          tmc_active = 1'b1;
    logic          stall_valid = 1'b0;
    logic [WW-1:0] stall_wid = '0;
    logic          branch_valid = 1'b0;
    logic [WW-1:0] branch_wid = '0;
    logic          branch_taken = 1'b0;
    logic [PW-1:0] branch_dest = '0;
    logic          req_valid;
    logic          req_ready = 1'b1;
    logic [WW-1:0] req_wid;
    logic [PW-1:0] req_pc;
    logic          rsp_valid = 1'b0;
    logic [WW-1:0] rsp_wid = '0;
    logic          busy;

    vx_fetch_warp_arbiter #(
        .NUM_WARPS(NW),
        .PC_WIDTH (PW),
        .RESET_PC (32'h80000000)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .wspawn_valid (wspawn_valid),
        .wspawn_mask  (wspawn_mask),
        .wspawn_pc    (wspawn_pc),
        .tmc_valid    (tmc_valid),
        .tmc_wid      (tmc_wid),
        .tmc_active   (tmc_active),
        .stall_valid  (stall_valid),
        .stall_wid    (stall_wid),
        .branch_valid (branch_valid),
        .branch_wid   (branch_wid),
        .branch_taken (branch_taken),
        .branch_dest  (branch_dest),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_wid      (req_wid),
        .req_pc       (req_pc),
        .rsp_valid    (rsp_valid),
        .rsp_wid      (rsp_wid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          rst;
        logic          ready;
        logic          rsp_v;
        logic [WW-1:0] rsp_w;
        logic          sp_v;
        logic [NW-1:0] sp_m;
        logic [PW-1:0] sp_pc;
        logic          br_v;
        logic [WW-1:0] br_w;
        logic [PW-1:0] br_d;
        logic          exp_v;
        logic [WW-1:0] exp_w;
        logic [PW-1:0] exp_pc;
    } vec_t;

    localparam int NV = 26;
    vec_t vecs [NV];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    task automatic expect_req(input string name, input logic v, input logic [WW-1:0] w,
                              input logic [PW-1:0] pc);
        check({name, " req_valid"}, PW'(req_valid), PW'(v));
        if (v) begin
            check({name, " req_wid"}, PW'(req_wid), PW'(w));
            check({name, " req_pc"}, req_pc, pc);
        end
    endtask

    // One clock: inputs were set before the call; outputs are sampled 1 time unit
    // after the edge, then single-cycle pulses are dropped.
    task automatic step();
        @(posedge clk);
        #1;
        wspawn_valid = 1'b0;
        tmc_valid    = 1'b0;
        stall_valid  = 1'b0;
        branch_valid = 1'b0;
        branch_taken = 1'b0;
        rsp_valid    = 1'b0;
    endtask

    task automatic do_reset();
        reset     = 1'b1;
        req_ready = 1'b1;
        step();
        step();
        reset = 1'b0;
    endtask

    function automatic vec_t mk(input logic rst, input logic ready, input logic rsp_v,
                                input logic [WW-1:0] rsp_w, input logic exp_v,
                                input logic [WW-1:0] exp_w, input logic [PW-1:0] exp_pc);
        vec_t r;
        r.rst = rst;      r.ready = ready;  r.rsp_v = rsp_v;  r.rsp_w = rsp_w;
        r.sp_v = 1'b0;    r.sp_m = '0;      r.sp_pc = '0;
        r.br_v = 1'b0;    r.br_w = '0;      r.br_d = '0;
        r.exp_v = exp_v;  r.exp_w = exp_w;  r.exp_pc = exp_pc;
        return r;
    endfunction

    task automatic rsp(input logic [WW-1:0] w);
        rsp_valid = 1'b1;
        rsp_wid   = w;
    endtask

    initial begin
        // Single warp from reset with rsp two cycles after fire, then reset
        // mid-request, then a spawn of warps 1-3 with immediate rsps and a hold.
        vecs[0]  = mk(1, 1, 0, 0, 0, 0, 32'h0);
        vecs[1]  = mk(1, 1, 0, 0, 0, 0, 32'h0);
        vecs[2]  = mk(0, 1, 0, 0, 1, 0, 32'h80000000);
        vecs[3]  = mk(0, 1, 0, 0, 0, 0, 32'h0);
        vecs[4]  = mk(0, 1, 1, 0, 0, 0, 32'h0);
        vecs[5]  = mk(0, 1, 0, 0, 1, 0, 32'h80000004);
        vecs[6]  = mk(0, 1, 0, 0, 0, 0, 32'h0);
        vecs[7]  = mk(0, 1, 1, 0, 0, 0, 32'h0);
        vecs[8]  = mk(0, 0, 0, 0, 1, 0, 32'h80000008);
        vecs[9]  = mk(1, 0, 0, 0, 0, 0, 32'h0);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 32'h0);
        vecs[11] = mk(0, 1, 1, 0, 1, 0, 32'h80000000);
        vecs[11].sp_v = 1'b1; vecs[11].sp_m = 4'b1110; vecs[11].sp_pc = 32'h1000;
        vecs[12] = mk(0, 1, 0, 0, 1, 1, 32'h1000);
        vecs[13] = mk(0, 1, 1, 0, 1, 2, 32'h1000);
        vecs[14] = mk(0, 1, 1, 1, 1, 3, 32'h1000);
        vecs[15] = mk(0, 1, 1, 2, 1, 0, 32'h80000004);
        vecs[16] = mk(0, 1, 1, 3, 1, 1, 32'h1004);
        vecs[17] = mk(0, 1, 1, 0, 1, 2, 32'h1004);
        vecs[18] = mk(0, 1, 1, 1, 1, 3, 32'h1004);
        vecs[19] = mk(0, 0, 1, 2, 1, 3, 32'h1004);
        vecs[20] = mk(0, 0, 0, 0, 1, 3, 32'h1004);
        vecs[20].br_v = 1'b1; vecs[20].br_w = 2'd3; vecs[20].br_d = 32'h5000;
        vecs[21] = mk(0, 0, 0, 0, 1, 3, 32'h1004);
        vecs[22] = mk(0, 0, 0, 0, 1, 3, 32'h1004);
        vecs[23] = mk(0, 0, 0, 0, 1, 3, 32'h1004);
        vecs[24] = mk(0, 1, 0, 0, 1, 0, 32'h80000008);
        vecs[25] = mk(0, 0, 0, 0, 1, 0, 32'h80000008);

        for (int i = 0; i < NV; i++) begin
            reset        = vecs[i].rst;
            req_ready    = vecs[i].ready;
            rsp_valid    = vecs[i].rsp_v;
            rsp_wid      = vecs[i].rsp_w;
            wspawn_valid = vecs[i].sp_v;
            wspawn_mask  = vecs[i].sp_m;
            wspawn_pc    = vecs[i].sp_pc;
            branch_valid = vecs[i].br_v;
            branch_wid   = vecs[i].br_w;
            branch_taken = vecs[i].br_v;
            branch_dest  = vecs[i].br_d;
            step();
            expect_req($sformatf("vec%0d", i), vecs[i].exp_v, vecs[i].exp_w, vecs[i].exp_pc);
            check($sformatf("vec%0d busy", i), PW'(busy), 32'h1);
        end

        // Reset values of the request registers.
        do_reset();
        check("reset req_valid", PW'(req_valid), 32'h0);
        check("reset req_wid", PW'(req_wid), 32'h0);
        check("reset req_pc", req_pc, 32'h0);
        check("reset busy", PW'(busy), 32'h1);

        // Warp 1 stalled is skipped until its taken branch; resumes at 0x2000.
        req_ready = 1'b0;
        wspawn_valid = 1'b1; wspawn_mask = 4'b1110; wspawn_pc = 32'h1000;
        step(); expect_req("stl1", 1, 0, 32'h80000000);
        stall_valid = 1'b1; stall_wid = 2'd1;
        step(); expect_req("stl2", 1, 0, 32'h80000000);
        req_ready = 1'b1;
        step(); expect_req("stl3", 1, 2, 32'h1000);
        rsp(0); step(); expect_req("stl4", 1, 3, 32'h1000);
        rsp(2); step(); expect_req("stl5", 1, 0, 32'h80000004);
        rsp(3);
        branch_valid = 1'b1; branch_wid = 2'd1; branch_taken = 1'b1; branch_dest = 32'h2000;
        step(); expect_req("stl6", 1, 2, 32'h1004);
        rsp(0); step(); expect_req("stl7", 1, 3, 32'h1004);
        rsp(2); step(); expect_req("stl8", 1, 0, 32'h80000008);
        rsp(3); step(); expect_req("stl9", 1, 1, 32'h2000);

        // Branch on the warp being selected in the same cycle, with a same-cycle
        // stall that the branch must override.
        do_reset();
        branch_valid = 1'b1; branch_wid = 2'd0; branch_taken = 1'b1; branch_dest = 32'h3000;
        stall_valid = 1'b1; stall_wid = 2'd0;
        step(); expect_req("sbr1", 1, 0, 32'h80000000);
        step(); expect_req("sbr2", 0, 0, 32'h0);
        rsp(0); step(); expect_req("sbr3", 0, 0, 32'h0);
        step(); expect_req("sbr4", 1, 0, 32'h3000);

        // PC wrap past 0xFFFFFFFC, then deactivate both warps and drain.
        do_reset();
        wspawn_valid = 1'b1; wspawn_mask = 4'b0010; wspawn_pc = 32'hFFFFFFFC;
        step(); expect_req("wrp1", 1, 0, 32'h80000000);
        step(); expect_req("wrp2", 1, 1, 32'hFFFFFFFC);
        rsp(0); step(); expect_req("wrp3", 0, 0, 32'h0);
        rsp(1); step(); expect_req("wrp4", 1, 0, 32'h80000004);
        step(); expect_req("wrp5", 1, 1, 32'h00000000);
        tmc_valid = 1'b1; tmc_wid = 2'd0; tmc_active = 1'b0;
        step(); expect_req("drn1", 0, 0, 32'h0);
        check("drn1 busy", PW'(busy), 32'h1);
        tmc_valid = 1'b1; tmc_wid = 2'd1; tmc_active = 1'b0;
        rsp(0); step(); expect_req("drn2", 0, 0, 32'h0);
        check("drn2 busy", PW'(busy), 32'h1);
        rsp(1); step(); expect_req("drn3", 0, 0, 32'h0);
        check("drn3 busy", PW'(busy), 32'h0);
        step(); expect_req("drn4", 0, 0, 32'h0);
        check("drn4 busy", PW'(busy), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
